// File: rtl/varray_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : varray_ctrl
// Brief    : Run allocation on the write side and in-order element streaming
//            through a one-entry output register on the read side.
// Revision : 1.0 - initial release
// ============================================================================
module varray_ctrl #(
    parameter int VIRTUAL_ELEMENT_WIDTH = 18,
    parameter int VIRTUAL_ADDR_BITS     = 16,
    parameter int MAX_RUN               = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [4:0]                       in_len,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
    input  logic                             seal,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_dat,
    output logic [VIRTUAL_ADDR_BITS-1:0]     out_addr,
    output logic                             out_group_start,
    output logic                             done,
    output logic                             vr_reset,
    output logic                             vr_we,
    output logic [VIRTUAL_ADDR_BITS-1:0]     vr_write_addr,
    output logic [4:0]                       vr_write_addr_len,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] vr_dat_w,
    output logic                             vr_re,
    output logic [VIRTUAL_ADDR_BITS-1:0]     vr_read_addr,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] vr_dat_r,
    input  logic [VIRTUAL_ADDR_BITS-1:0]     vr_varray_len,
    input  logic                             vr_is_new_superscalar_group,
    input  logic                             vr_queue_almost_full
);

    // Highest wptr from which a maximum-length run still fits the address space.
    localparam logic [VIRTUAL_ADDR_BITS-1:0] c_wptr_limit =
        VIRTUAL_ADDR_BITS'((2 ** VIRTUAL_ADDR_BITS) - 1 - MAX_RUN);

    logic [VIRTUAL_ADDR_BITS-1:0]     wptr_q, wptr_d;
    logic [VIRTUAL_ADDR_BITS-1:0]     rptr_q, rptr_d;
    logic                             sealed_q, sealed_d;
    logic                             out_valid_q, out_valid_d;
    logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_dat_q, out_dat_d;
    logic [VIRTUAL_ADDR_BITS-1:0]     out_addr_q, out_addr_d;
    logic                             out_gs_q, out_gs_d;
    logic                             done_q, done_d;

    logic w_restart;
    logic w_handshake;
    logic w_issue;

    // Handshake and varray-facing controls.
    always_comb begin
        w_restart         = reset | flush;
        in_ready          = !vr_queue_almost_full && !sealed_q && !w_restart &&
                            (wptr_q <= c_wptr_limit);
        w_handshake       = in_valid & in_ready;
        w_issue           = (rptr_q < vr_varray_len) && (!out_valid_q || out_ready) &&
                            !w_restart;
        vr_reset          = w_restart;
        vr_we             = w_handshake & (in_len != 5'd0);
        vr_write_addr     = wptr_q;
        vr_write_addr_len = in_len;
        vr_dat_w          = in_dat;
        vr_re             = w_issue;
        vr_read_addr      = rptr_q;
        out_valid         = out_valid_q;
        out_dat           = out_dat_q;
        out_addr          = out_addr_q;
        out_group_start   = out_gs_q;
        done              = done_q;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        sealed_d    = sealed_q | seal;
        out_valid_d = out_valid_q;
        out_dat_d   = out_dat_q;
        out_addr_d  = out_addr_q;
        out_gs_d    = out_gs_q;

        if (vr_we) begin
            wptr_d = wptr_q + VIRTUAL_ADDR_BITS'(in_len);
        end

        if (w_issue) begin
            out_dat_d   = vr_dat_r;
            out_addr_d  = rptr_q;
            out_gs_d    = vr_is_new_superscalar_group;
            out_valid_d = 1'b1;
            rptr_d      = rptr_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A write in flight has not reached vr_varray_len yet, so it blocks done.
        done_d = sealed_d && !vr_we && (rptr_d == vr_varray_len) && !out_valid_d;

        if (w_restart) begin
            wptr_d      = '0;
            rptr_d      = '0;
            sealed_d    = 1'b0;
            out_valid_d = 1'b0;
            out_dat_d   = '0;
            out_addr_d  = '0;
            out_gs_d    = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            sealed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            out_addr_q  <= '0;
            out_gs_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            sealed_q    <= sealed_d;
            out_valid_q <= out_valid_d;
            out_dat_q   <= out_dat_d;
            out_addr_q  <= out_addr_d;
            out_gs_q    <= out_gs_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_varray_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_varray_ctrl
// Brief    : Self-checking bench for varray_ctrl with a behavioural varray and
//            an element-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_varray_ctrl;
    localparam int W  = 18;
    localparam int A  = 16;
    localparam int MR = 16;

    logic clk = 1'b0;
    logic reset, flush, in_valid, seal, out_ready;
    logic [4:0] in_len;
    logic [W-1:0] in_dat;
    logic in_ready, out_valid, out_group_start, done, vr_reset, vr_we, vr_re;
    logic [W-1:0] out_dat, vr_dat_w, vr_dat_r;
    logic [A-1:0] out_addr, vr_write_addr, vr_read_addr, vr_varray_len;
    logic [4:0] vr_write_addr_len;
    logic vr_is_new_superscalar_group, vr_queue_almost_full;
    logic af_force, af_auto;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    varray_ctrl #(.VIRTUAL_ELEMENT_WIDTH(W), .VIRTUAL_ADDR_BITS(A), .MAX_RUN(MR)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_len(in_len), .in_dat(in_dat),
        .seal(seal),
        .out_valid(out_valid), .out_ready(out_ready), .out_dat(out_dat),
        .out_addr(out_addr), .out_group_start(out_group_start), .done(done),
        .vr_reset(vr_reset), .vr_we(vr_we), .vr_write_addr(vr_write_addr),
        .vr_write_addr_len(vr_write_addr_len), .vr_dat_w(vr_dat_w),
        .vr_re(vr_re), .vr_read_addr(vr_read_addr), .vr_dat_r(vr_dat_r),
        .vr_varray_len(vr_varray_len),
        .vr_is_new_superscalar_group(vr_is_new_superscalar_group),
        .vr_queue_almost_full(vr_queue_almost_full)
    );

    // Behavioural varray: storage, run-start flags, registered committed length.
    logic [W-1:0] mem [65536];
    logic         start_bit [65536];
    logic [A-1:0] va_len = '0;

    always @(posedge clk) begin
        if (vr_reset) begin
            va_len <= '0;
        end else if (vr_we) begin
            for (int i = 0; i < MR; i++) begin
                if (i < int'(vr_write_addr_len)) begin
                    mem[vr_write_addr + A'(i)]       <= vr_dat_w;
                    start_bit[vr_write_addr + A'(i)] <= (i == 0);
                end
            end
            va_len <= va_len + A'(vr_write_addr_len);
        end
    end

    assign vr_varray_len               = va_len;
    assign vr_dat_r                    = mem[vr_read_addr];
    assign vr_is_new_superscalar_group = start_bit[vr_read_addr];
    assign vr_queue_almost_full        = af_force | (af_auto & ((va_len - vr_read_addr) >= 16'd40));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference model: every accepted run becomes len queued elements.
    typedef struct packed {
        logic [W-1:0] dat;
        logic [A-1:0] addr;
        logic         gs;
    } elem_t;

    elem_t expq[$];
    elem_t outlog[$];
    int    m_wptr = 0;
    bit    m_sealed = 1'b0;
    bit    p_hold = 1'b0;
    elem_t p_elem;
    bit    log_en = 1'b0;
    int    hs_count = 0;
    logic [A-1:0] last_addr = '0;

    always @(negedge clk) begin
        bit    exp_rdy;
        elem_t cur;
        elem_t e;
        exp_rdy = !vr_queue_almost_full && !m_sealed && !reset && !flush &&
                  (m_wptr <= (1 << A) - 1 - MR);
        cur = '{dat: out_dat, addr: out_addr, gs: out_group_start};
        chk("in_ready", in_ready, exp_rdy);
        chk("vr_we", vr_we, exp_rdy && in_valid && (in_len != 5'd0));
        chk("vr_reset", vr_reset, reset || flush);
        if (reset || flush || (out_valid && !out_ready)) chk("vr_re_blocked", vr_re, 1'b0);
        if (p_hold) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_dat", cur.dat, p_elem.dat);
            chk("hold_addr", cur.addr, p_elem.addr);
            chk("hold_gs", cur.gs, p_elem.gs);
        end
        p_hold = out_valid && !out_ready && !reset && !flush;
        p_elem = cur;
        if (reset || flush) begin
            expq.delete();
            m_wptr   = 0;
            m_sealed = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                hs_count++;
                last_addr = out_addr;
                if (log_en) outlog.push_back(cur);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra: got element at addr 0x%0h, expected none", out_addr);
                end else begin
                    e = expq.pop_front();
                    chk("out_addr", out_addr, e.addr);
                    chk("out_dat", out_dat, e.dat);
                    chk("out_gs", out_group_start, e.gs);
                end
            end
            if (in_valid && exp_rdy && in_len != 5'd0) begin
                for (int i = 0; i < int'(in_len); i++) begin
                    e.dat  = in_dat;
                    e.addr = A'(m_wptr + i);
                    e.gs   = (i == 0);
                    expq.push_back(e);
                end
                m_wptr += int'(in_len);
            end
            if (seal) m_sealed = 1'b1;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_len = 5'd0; in_dat = '0;
        seal = 1'b0; flush = 1'b0; af_force = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while ((expq.size() != 0 || out_valid) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", expq.size(), 0);
        cyc();
    endtask

    typedef struct {
        bit           v;
        bit [4:0]     len;
        bit [W-1:0]   dat;
        bit           af;
        bit           rdy;
        bit           we;
        bit [A-1:0]   waddr;
        bit           ov;
        bit [A-1:0]   oaddr;
    } wvec_t;

    typedef struct {
        bit [A-1:0] addr;
        bit [W-1:0] dat;
        bit         gs;
    } ovec_t;

    localparam logic [W-1:0] DA = 18'h12345, DB = 18'h0ABCD, DC = 18'h3FFFF, DD = 18'h00001;

    initial begin
        wvec_t wv[6];
        ovec_t ov[6];
        int    nw, k;
        bit    blocked, found;
        int    we_after;

        wv[0] = '{1'b1, 5'd3, DA, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 16'd0};
        wv[1] = '{1'b1, 5'd2, DB, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 16'd0};
        wv[2] = '{1'b1, 5'd0, DC, 1'b0, 1'b1, 1'b0, 16'd5, 1'b1, 16'd0};
        wv[3] = '{1'b1, 5'd1, DD, 1'b1, 1'b0, 1'b0, 16'd5, 1'b1, 16'd1};
        wv[4] = '{1'b0, 5'd4, DC, 1'b0, 1'b1, 1'b0, 16'd5, 1'b1, 16'd2};
        wv[5] = '{1'b1, 5'd1, DD, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 16'd3};
        ov[0] = '{16'd0, DA, 1'b1};
        ov[1] = '{16'd1, DA, 1'b0};
        ov[2] = '{16'd2, DA, 1'b0};
        ov[3] = '{16'd3, DB, 1'b1};
        ov[4] = '{16'd4, DB, 1'b0};
        ov[5] = '{16'd5, DD, 1'b1};

        idle_inputs();
        reset = 1'b1; out_ready = 1'b0; af_auto = 1'b0;

        // Reset state and basic run sequencing.
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_gs", out_group_start, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_vr_re", vr_re, 1'b0);
        chk("rst_waddr", vr_write_addr, 0);
        chk("rst_raddr", vr_read_addr, 0);
        cyc();
        outlog.delete();
        log_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = wv[i].v; in_len = wv[i].len; in_dat = wv[i].dat; af_force = wv[i].af;
            @(negedge clk);
            chk("t1_in_ready", in_ready, wv[i].rdy);
            chk("t1_vr_we", vr_we, wv[i].we);
            chk("t1_waddr", vr_write_addr, wv[i].waddr);
            chk("t1_out_valid", out_valid, wv[i].ov);
            chk("t1_out_addr", out_addr, wv[i].oaddr);
            cyc();
        end
        idle_inputs();
        k = 0;
        while (outlog.size() < 6 && k < 30) begin cyc(); k++; end
        chk("t1_count", outlog.size(), 6);
        for (int j = 0; j < 6; j++) begin
            if (j < outlog.size()) begin
                chk("t1_log_addr", outlog[j].addr, ov[j].addr);
                chk("t1_log_dat", outlog[j].dat, ov[j].dat);
                chk("t1_log_gs", outlog[j].gs, ov[j].gs);
            end
        end
        log_en = 1'b0;
        drain(50);

        // Consumer stall after a len-4 run.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_len = 5'd4; in_dat = 18'h00011;
        cyc();
        idle_inputs();
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall_valid", out_valid, 1'b1);
            chk("t2_stall_addr", out_addr, 0);
            chk("t2_stall_re", vr_re, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_burst_valid", out_valid, 1'b1);
            chk("t2_burst_addr", out_addr, i);
            cyc();
        end
        drain(20);

        // Throttling on queue_almost_full.
        do_reset();
        af_auto = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_len = 5'd16; in_dat = 18'h2C0DE;
        nw = 0; blocked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vr_we) nw++;
            if (!in_ready) blocked = 1'b1;
            cyc();
        end
        chk("t3_blocked", blocked, 1'b1);
        chk("t3_writes_before_full", nw, 3);
        out_ready = 1'b1;
        we_after = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vr_we) we_after++;
            cyc();
        end
        chk("t3_resumed", (we_after > 0), 1'b1);
        drain(2000);
        af_auto = 1'b0;

        // Address-space exhaustion and recovery by flush.
        do_reset();
        out_ready = 1'b1; hs_count = 0;
        in_valid = 1'b1; in_len = 5'd16; in_dat = 18'h00F0F;
        nw = 0; k = 0;
        @(negedge clk);
        while (in_ready && k < 5000) begin
            if (vr_we) nw++;
            cyc();
            @(negedge clk);
            k++;
        end
        chk("t4_writes", nw, 4095);
        chk("t4_wptr", vr_write_addr, 65520);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("t4_ready_low", in_ready, 1'b0);
        end
        cyc();
        drain(70000);
        chk("t4_drained", hs_count, 65520);
        chk("t4_last_addr", last_addr, 65519);
        flush = 1'b1;
        @(negedge clk);
        chk("t4_flush_ready", in_ready, 1'b0);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_after_ready", in_ready, 1'b1);
        chk("t4_after_waddr", vr_write_addr, 0);
        cyc();

        // Seal with a same-cycle run, then done after the final handshake.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_len = 5'd2; in_dat = 18'h0002A; seal = 1'b1;
        @(negedge clk);
        chk("t5_seal_we", vr_we, 1'b1);
        cyc();
        seal = 1'b0; in_len = 5'd1;
        @(negedge clk);
        chk("t5_sealed_ready", in_ready, 1'b0);
        chk("t5_sealed_we", vr_we, 1'b0);
        chk("t5_done_early", done, 1'b0);
        cyc();
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_addr == 16'd1) found = 1'b1;
            else cyc();
        end
        chk("t5_last_seen", found, 1'b1);
        chk("t5_done_at_last", done, 1'b0);
        cyc();
        @(negedge clk);
        chk("t5_done", done, 1'b1);
        chk("t5_done_addr", out_addr, 1);
        chk("t5_done_valid", out_valid, 1'b0);
        chk("t5_done_ready", in_ready, 1'b0);
        cyc();
        idle_inputs();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_done_cleared", done, 1'b0);
        cyc();

        // Flush with a presented element and three undrained behind it.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_len = 5'd4; in_dat = 18'h00033;
        cyc();
        idle_inputs();
        cyc();
        flush = 1'b1; in_valid = 1'b1; in_len = 5'd2; in_dat = 18'h00077;
        @(negedge clk);
        chk("t6_pre_valid", out_valid, 1'b1);
        chk("t6_vr_reset", vr_reset, 1'b1);
        chk("t6_no_re", vr_re, 1'b0);
        chk("t6_no_we", vr_we, 1'b0);
        cyc();
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid_cleared", out_valid, 1'b0);
        chk("t6_no_re_after", vr_re, 1'b0);
        chk("t6_we", vr_we, 1'b1);
        chk("t6_waddr", vr_write_addr, 0);
        cyc();
        idle_inputs();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else cyc();
        end
        chk("t6_out_seen", found, 1'b1);
        chk("t6_out_addr", out_addr, 0);
        chk("t6_out_dat", out_dat, 18'h00077);
        chk("t6_out_gs", out_group_start, 1'b1);
        cyc();
        drain(20);

        // Randomized traffic checked by the reference model.
        do_reset();
        af_auto = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_len    = ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, MR));
            in_dat    = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            af_force  = ($urandom_range(0, 9) == 0);
            seal      = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 249) == 0);
            reset     = ($urandom_range(0, 599) == 0);
            cyc();
        end
        idle_inputs();
        reset = 1'b0;
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
